// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter that time-shares one external ALU among N_REQ requesters.
// Each accepted op spends one cycle on registered ALU inputs, then waits in RESP until consumed.
module alu_share_ctrl #(
  parameter int WIDTH = 64,
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [3*N_REQ-1:0]     req_cntrl,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [2:0]             alu_cntrl,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic [3:0]             alu_flags,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_result,
  output logic [3:0]             rsp_flags,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                        state_q, state_d;
  logic [IDW-1:0]                last_q, gnt, idx;
  logic                          gnt_vld;
  logic [N_REQ-1:0][WIDTH-1:0]   a_arr, b_arr;
  logic [N_REQ-1:0][2:0]         c_arr;

  for (genvar k = 0; k < N_REQ; k++) begin : g_lane
    assign a_arr[k] = req_a[WIDTH*k +: WIDTH];
    assign b_arr[k] = req_b[WIDTH*k +: WIDTH];
    assign c_arr[k] = req_cntrl[3*k +: 3];
  end

  // Walk offsets from farthest to nearest so the requester just after 'last' wins;
  // offset N_REQ wraps back to 'last' itself, giving it lowest priority.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = last_q + IDW'(i);
      if (req_valid[idx]) begin
        gnt     = idx;
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_vld) req_ready[gnt] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld)   state_d = EXEC;
      EXEC:                   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q     <= IDW'(N_REQ - 1);
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cntrl  <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      if (state_q == IDLE && gnt_vld) begin
        alu_a     <= a_arr[gnt];
        alu_b     <= b_arr[gnt];
        alu_cntrl <= c_arr[gnt];
        rsp_id    <= gnt;
        last_q    <= gnt;
      end
      if (state_q == EXEC) begin
        rsp_result <= alu_result;
        rsp_flags  <= alu_flags;
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed + randomized bench for alu_share_ctrl with a behavioural ALU stand-in
// and a transaction-level arbitration model.
module tb_alu_share_ctrl;
  localparam int W = 64;
  localparam int N = 4;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid, req_ready;
  logic [3*N-1:0]    req_cntrl;
  logic [W*N-1:0]    req_a, req_b;
  logic [W-1:0]      alu_a, alu_b, alu_result;
  logic [2:0]        alu_cntrl;
  logic [3:0]        alu_flags, rsp_flags;
  logic              rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_result;

  logic [W-1:0] ta [N];
  logic [W-1:0] tb [N];
  logic [2:0]   tc [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      req_a[W*k +: W]   = ta[k];
      req_b[W*k +: W]   = tb[k];
      req_cntrl[3*k +: 3] = tc[k];
    end
  end

  // ALU behaviour: returns {negative, zero, overflow, carry_out, result}
  function automatic logic [W+3:0] alu_f(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         v, co;
    s = '0; v = 1'b0; co = 1'b0;
    case (c)
      3'b000: r = b;
      3'b010: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; co = s[W];
                    v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      3'b011: begin s = {1'b0, a} - {1'b0, b}; r = s[W-1:0]; co = s[W];
                    v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: r = '0;
    endcase
    return {r[W-1], (r == '0), v, co, r};
  endfunction

  logic [W+3:0] alu_out;
  assign alu_out    = alu_f(alu_cntrl, alu_a, alu_b);
  assign alu_result = alu_out[W-1:0];
  assign alu_flags  = alu_out[W+3:W];

  alu_share_ctrl #(.WIDTH(W), .N_REQ(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_cntrl(req_cntrl), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_req(input int k, input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    tc[k] = c; ta[k] = a; tb[k] = b;
  endtask

  // model state for the randomized phase
  int           m_phase, m_last, g;
  logic         hold [N];
  logic [N-1:0] exp_rdy;
  logic [IDW-1:0] e_id;
  logic [W+3:0] e_out;

  initial begin
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    for (int k = 0; k < N; k++) set_req(k, 3'b000, '0, '0);
    do_reset();
    settle();

    // reset state
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_cntrl", alu_cntrl, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_flags", rsp_flags, 0);

    // single add from requester 2
    rsp_ready = 1'b1;
    set_req(2, 3'b010, 64'd5, 64'd7);
    req_valid = 4'b0100;
    settle();
    chk("add_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    settle();
    chk("add_exec_valid", rsp_valid, 0);
    chk("add_exec_busy", busy, 1);
    chk("add_alu_a", alu_a, 5);
    chk("add_alu_b", alu_b, 7);
    chk("add_alu_cntrl", alu_cntrl, 3'b010);
    tick();
    chk("add_rsp_valid", rsp_valid, 1);
    chk("add_rsp_id", rsp_id, 2);
    chk("add_rsp_result", rsp_result, 12);
    chk("add_rsp_flags", rsp_flags, 4'b0000);
    tick();
    chk("add_done_valid", rsp_valid, 0);

    // round robin from a fresh reset: grant order 0,1,2,3,0
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 3'b011, 64'(k), 64'(k));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      settle();
      chk($sformatf("rr_ready%0d", n), req_ready, 4'b0001 << (n % N));
      tick();
      chk($sformatf("rr_exec_ready%0d", n), req_ready, 0);
      tick();
      chk($sformatf("rr_id%0d", n), rsp_id, n % N);
      chk($sformatf("rr_result%0d", n), rsp_result, 0);
      chk($sformatf("rr_flags%0d", n), rsp_flags, 4'b0100);
      tick();
    end

    // backpressure: last=0, so requester 1 wins next
    set_req(1, 3'b110, 64'hFF, 64'h0F);
    rsp_ready = 1'b0;
    settle();
    chk("bp_ready", req_ready, 4'b0010);
    tick();
    tick();
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("bp_valid%0d", n), rsp_valid, 1);
      chk($sformatf("bp_id%0d", n), rsp_id, 1);
      chk($sformatf("bp_result%0d", n), rsp_result, 64'hF0);
      chk($sformatf("bp_ready%0d", n), req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    settle();
    chk("bp_accept_ready", req_ready, 0);
    tick();
    chk("bp_next_ready", req_ready, 4'b0100);
    req_valid = '0;
    settle();

    // signed overflow on add: last=1, only requester 0 valid
    set_req(0, 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    req_valid = 4'b0001;
    settle();
    chk("ovf_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    chk("ovf_result", rsp_result, 64'h8000_0000_0000_0000);
    chk("ovf_flags", rsp_flags, 4'b1010);
    tick();

    // reset during EXEC
    set_req(2, 3'b101, 64'h3, 64'h4);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("rexec_valid", rsp_valid, 0);
    chk("rexec_busy", busy, 0);
    chk("rexec_result", rsp_result, 0);
    req_valid = 4'b1111;
    settle();
    chk("rexec_prio", req_ready, 4'b0001);
    req_valid = 4'b0010;
    settle();
    chk("rexec_solo", req_ready, 4'b0010);

    // reset during RESP with consumer stalled
    rsp_ready = 1'b0;
    tick();
    req_valid = '0;
    tick();
    chk("rresp_pre_valid", rsp_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("rresp_valid", rsp_valid, 0);
    chk("rresp_busy", busy, 0);
    chk("rresp_id", rsp_id, 0);
    req_valid = 4'b1111;
    settle();
    chk("rresp_prio", req_ready, 4'b0001);

    // requester 3 pulses valid only while controller is busy
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b1001;
    settle();
    chk("wd_exec_ready", req_ready, 0);
    tick();
    req_valid = '0;
    settle();
    chk("wd_rsp_id", rsp_id, 0);
    chk("wd_resp_ready", req_ready, 0);
    tick();
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("wd_ready%0d", n), req_ready, 0);
      chk($sformatf("wd_valid%0d", n), rsp_valid, 0);
      tick();
    end

    // randomized traffic against the transaction model
    do_reset();
    m_phase = 0; m_last = N - 1;
    e_id = '0; e_out = '0;
    for (int k = 0; k < N; k++) hold[k] = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (hold[k] && $urandom_range(15) == 0) hold[k] = 1'b0;
        else if (!hold[k] && $urandom_range(1) == 1) begin
          hold[k] = 1'b1;
          set_req(k, 3'($urandom_range(7)), {$urandom, $urandom},
                  ($urandom_range(3) == 0) ? 64'd1 : {$urandom, $urandom});
        end
        req_valid[k] = hold[k];
      end
      rsp_ready = ($urandom_range(2) != 0);
      settle();
      g = -1;
      if (m_phase == 0)
        for (int i = 1; i <= N; i++)
          if (g < 0 && hold[(m_last + i) % N]) g = (m_last + i) % N;
      exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk("rnd_ready", req_ready, exp_rdy);
      chk("rnd_valid", rsp_valid, m_phase == 2);
      chk("rnd_busy", busy, m_phase != 0);
      if (m_phase == 2) begin
        chk("rnd_id", rsp_id, e_id);
        chk("rnd_result", rsp_result, e_out[W-1:0]);
        chk("rnd_flags", rsp_flags, e_out[W+3:W]);
      end
      case (m_phase)
        0: if (g >= 0) begin
             e_id = IDW'(g);
             e_out = alu_f(tc[g], ta[g], tb[g]);
             m_last = g; hold[g] = 1'b0; m_phase = 1;
           end
        1: m_phase = 2;
        default: if (rsp_ready) m_phase = 0;
      endcase
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
